// File: rtl/eth_rx_slot_ring.sv
// Multi-slot receive frame ring: a writer FSM captures frames into 2**SLOT_W
// slots of one shared RAM, and the consumer reads them in commit order.
module eth_rx_slot_ring #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7,
  parameter int SLOT_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_en,
  input  logic              i_pckt_end,
  input  logic              i_pckt_abort,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [ADDR_W:0]   o_rd_len,
  input  logic              i_rd_pop,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_irq,
  output logic [CNT_W-1:0]  o_drop_cnt
);

  localparam logic [SLOT_W-1:0] SLOT_ONE = SLOT_W'(1);
  localparam logic [SLOT_W:0]   CNT_ONE  = (SLOT_W + 1)'(1);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);
  localparam logic [CNT_W-1:0]  DROP_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_ram [2**(SLOT_W+ADDR_W)];
  logic [ADDR_W:0]     r_len [2**SLOT_W];
  logic [SLOT_W-1:0]   r_wp;
  logic [SLOT_W-1:0]   r_rp;
  logic [SLOT_W:0]     r_count;
  logic [ADDR_W:0]     r_cur_len;
  logic [DATA_W-1:0]   r_rd_data;
  logic [CNT_W-1:0]    r_drop_cnt;

  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_ram_we;
  logic                w_commit;
  logic                w_drop_inc;
  logic [ADDR_W:0]     w_addr_p1;
  logic [ADDR_W:0]     w_len_max;
  logic [ADDR_W:0]     w_cur_len_nxt;

  // count can only reach 2**SLOT_W, so its top bit alone marks FULL
  assign w_empty   = (r_count == '0);
  assign w_full    = r_count[SLOT_W];
  assign w_pop     = i_rd_pop & ~w_empty;
  assign w_addr_p1 = {1'b0, i_wr_addr} + LEN_ONE;
  assign w_len_max = (w_addr_p1 > r_cur_len) ? w_addr_p1 : r_cur_len;

  always_comb begin
    w_state_nxt   = r_state;
    w_ram_we      = 1'b0;
    w_commit      = 1'b0;
    w_drop_inc    = 1'b0;
    w_cur_len_nxt = r_cur_len;
    case (r_state)
      S_IDLE: begin
        if (i_wr_en) begin
          if (w_full) begin
            w_state_nxt = S_DROP;
          end else begin
            w_state_nxt   = S_FILL;
            w_ram_we      = 1'b1;
            w_cur_len_nxt = w_addr_p1;
          end
        end
      end
      S_FILL: begin
        if (i_pckt_abort) begin
          w_state_nxt   = S_IDLE;
          w_cur_len_nxt = '0;
        end else begin
          if (i_wr_en) begin
            w_ram_we      = 1'b1;
            w_cur_len_nxt = w_len_max;
          end
          if (i_pckt_end) begin
            w_commit    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (i_pckt_abort) begin
          w_state_nxt = S_IDLE;
        end else if (i_pckt_end) begin
          w_drop_inc  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_cur_len  <= '0;
      r_drop_cnt <= '0;
      r_rd_data  <= '0;
      for (int i = 0; i < 2**SLOT_W; i++) r_len[i] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur_len <= w_commit ? '0 : w_cur_len_nxt;
      r_rd_data <= r_ram[{r_rp, i_rd_addr}];
      if (w_commit) begin
        r_len[r_wp] <= w_cur_len_nxt;
        r_wp        <= r_wp + SLOT_ONE;
      end
      if (w_pop) r_rp <= r_rp + SLOT_ONE;
      if (w_commit && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_commit && w_pop) r_count <= r_count - CNT_ONE;
      if (w_drop_inc && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + DROP_ONE;
    end
  end

  // Frame storage carries no reset so it maps onto block RAM
  always_ff @(posedge i_clk) begin
    if (w_ram_we) r_ram[{r_wp, i_wr_addr}] <= i_wr_data;
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_len   = w_empty ? '0 : r_len[r_rp];
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_irq      = ~w_empty;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_eth_rx_slot_ring.sv
// Directed bench for eth_rx_slot_ring; a second instance with a 2-bit drop
// counter shares the stimulus so counter saturation is reachable quickly.
module tb_eth_rx_slot_ring;

  logic        clk;
  logic        rst;
  logic        rst_s;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        pend;
  logic        pabort;
  logic [6:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  rd_len;
  logic        rd_pop;
  logic        empty;
  logic        full;
  logic        irq;
  logic [15:0] drop;
  logic [31:0] rd_data_s;
  logic [7:0]  rd_len_s;
  logic        empty_s;
  logic        full_s;
  logic        irq_s;
  logic [1:0]  drop_s;

  int vectors;
  int miscompares;

  eth_rx_slot_ring dut (
    .i_clk(clk), .i_rst(rst), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_wr_en(wr_en), .i_pckt_end(pend), .i_pckt_abort(pabort),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_len(rd_len),
    .i_rd_pop(rd_pop), .o_empty(empty), .o_full(full), .o_irq(irq),
    .o_drop_cnt(drop)
  );

  eth_rx_slot_ring #(.CNT_W(2)) dut_s (
    .i_clk(clk), .i_rst(rst_s), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_wr_en(wr_en), .i_pckt_end(pend), .i_pckt_abort(pabort),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data_s), .o_rd_len(rd_len_s),
    .i_rd_pop(rd_pop), .o_empty(empty_s), .o_full(full_s), .o_irq(irq_s),
    .o_drop_cnt(drop_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d,
                    input logic e, input logic ab, input logic pop);
    wr_addr = a; wr_data = d; wr_en = 1'b1; pend = e; pabort = ab; rd_pop = pop;
    tick();
    wr_en = 1'b0; pend = 1'b0; pabort = 1'b0; rd_pop = 1'b0;
  endtask

  task automatic strobe(input logic e, input logic ab, input logic pop);
    wr_en = 1'b0; pend = e; pabort = ab; rd_pop = pop;
    tick();
    pend = 1'b0; pabort = 1'b0; rd_pop = 1'b0;
  endtask

  task automatic frame(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) wr(7'(i), base + 32'(i), 1'b0, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b0; rst_s = 1'b1;
    wr_addr = '0; wr_data = '0; wr_en = 1'b0; pend = 1'b0; pabort = 1'b0;
    rd_addr = '0; rd_pop = 1'b0;

    // 1: reset state and a single 8-word frame
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rd_len", 32'(rd_len), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    frame(8, 32'h1234_5678);
    chk("t1_empty", 32'(empty), 32'd0);
    chk("t1_irq", 32'(irq), 32'd1);
    chk("t1_rd_len", 32'(rd_len), 32'd8);
    rd_addr = 7'd3;
    tick();
    chk("t1_rd_data", rd_data, 32'h1234_567b);

    // 2: fill all slots, drop a frame whose first word meets a pop while FULL
    do_reset();
    frame(1, 32'h100);
    frame(2, 32'h200);
    frame(3, 32'h300);
    frame(4, 32'h400);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_len1", 32'(rd_len), 32'd1);
    wr(7'd0, 32'h500, 1'b0, 1'b0, 1'b1);
    chk("t2_full_after_pop", 32'(full), 32'd0);
    chk("t2_len2", 32'(rd_len), 32'd2);
    wr(7'd1, 32'h501, 1'b0, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0);
    chk("t2_drop", 32'(drop), 32'd1);
    chk("t2_count", 32'(dut.r_count), 32'd3);
    strobe(1'b0, 1'b0, 1'b1);
    chk("t2_len3", 32'(rd_len), 32'd3);
    rd_addr = 7'd2;
    tick();
    chk("t2_rd_data", rd_data, 32'h302);
    strobe(1'b0, 1'b0, 1'b1);
    chk("t2_len4", 32'(rd_len), 32'd4);
    strobe(1'b0, 1'b0, 1'b1);
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_len_empty", 32'(rd_len), 32'd0);
    strobe(1'b0, 1'b0, 1'b1);
    chk("t2_pop_empty_count", 32'(dut.r_count), 32'd0);
    chk("t2_pop_empty_rp", 32'(dut.r_rp), 32'd0);

    // 3: abort, abort winning over end, then slot 0 reused
    do_reset();
    for (int i = 0; i < 6; i++) wr(7'(i), 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
    strobe(1'b0, 1'b1, 1'b0);
    chk("t3_abort_empty", 32'(empty), 32'd1);
    chk("t3_abort_wp", 32'(dut.r_wp), 32'd0);
    for (int i = 0; i < 3; i++) wr(7'(i), 32'hF0 + 32'(i), 1'b0, 1'b0, 1'b0);
    strobe(1'b1, 1'b1, 1'b0);
    chk("t3_abort_wins", 32'(empty), 32'd1);
    frame(2, 32'hB0);
    chk("t3_rd_len", 32'(rd_len), 32'd2);
    chk("t3_count", 32'(dut.r_count), 32'd1);
    chk("t3_wp", 32'(dut.r_wp), 32'd1);
    rd_addr = 7'd1;
    tick();
    chk("t3_rd_data", rd_data, 32'hB1);

    // 4: commit and pop in the same cycle, write pointer wrapping 3 -> 0
    do_reset();
    frame(1, 32'h10);
    frame(1, 32'h20);
    frame(1, 32'h30);
    chk("t4_wp3", 32'(dut.r_wp), 32'd3);
    wr(7'd0, 32'h40, 1'b0, 1'b0, 1'b0);
    wr(7'd1, 32'h41, 1'b0, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b1);
    chk("t4_count", 32'(dut.r_count), 32'd3);
    chk("t4_wp_wrap", 32'(dut.r_wp), 32'd0);
    chk("t4_rp", 32'(dut.r_rp), 32'd1);
    chk("t4_len_s1", 32'(rd_len), 32'd1);
    frame(3, 32'h50);
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_count_full", 32'(dut.r_count), 32'd4);
    strobe(1'b0, 1'b0, 1'b1);
    chk("t4_len_s2", 32'(rd_len), 32'd1);
    strobe(1'b0, 1'b0, 1'b1);
    chk("t4_len_s3", 32'(rd_len), 32'd2);
    rd_addr = 7'd1;
    tick();
    chk("t4_data_s3", rd_data, 32'h41);
    strobe(1'b0, 1'b0, 1'b1);
    chk("t4_len_s0", 32'(rd_len), 32'd3);
    chk("t4_rp_wrap", 32'(dut.r_rp), 32'd0);
    rd_addr = 7'd2;
    tick();
    chk("t4_data_s0", rd_data, 32'h52);

    // 5: out-of-order writes, and a word written together with end
    do_reset();
    wr(7'd9, 32'h90, 1'b0, 1'b0, 1'b0);
    wr(7'd2, 32'h92, 1'b0, 1'b0, 1'b0);
    wr(7'd5, 32'h95, 1'b0, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0);
    chk("t5_len10", 32'(rd_len), 32'd10);
    strobe(1'b0, 1'b0, 1'b1);
    wr(7'd3, 32'hC3, 1'b0, 1'b0, 1'b0);
    wr(7'd11, 32'hCB, 1'b1, 1'b0, 1'b0);
    chk("t5_len12", 32'(rd_len), 32'd12);
    rd_addr = 7'd11;
    tick();
    chk("t5_rd_data", rd_data, 32'hCB);

    // 6: reset mid-frame, then drop counting up to saturation
    rst = 1'b1; rst_s = 1'b1;
    tick();
    rst = 1'b0; rst_s = 1'b0;
    for (int i = 0; i < 3; i++) wr(7'(i), 32'hD0 + 32'(i), 1'b0, 1'b0, 1'b0);
    rst = 1'b1; rst_s = 1'b1;
    #2;
    rst = 1'b0; rst_s = 1'b0;
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_drop0", 32'(drop), 32'd0);
    chk("t6_wp0", 32'(dut.r_wp), 32'd0);
    frame(1, 32'hE0);
    chk("t6_wp1", 32'(dut.r_wp), 32'd1);
    rd_addr = 7'd0;
    tick();
    chk("t6_rd_data", rd_data, 32'hE0);
    frame(1, 32'hE1);
    frame(1, 32'hE2);
    frame(1, 32'hE3);
    chk("t6_full", 32'(full), 32'd1);
    for (int i = 0; i < 3; i++) begin
      wr(7'd0, 32'hEE, 1'b0, 1'b0, 1'b0);
      strobe(1'b1, 1'b0, 1'b0);
    end
    chk("t6_drop3", 32'(drop), 32'd3);
    chk("t6_small_at_max", 32'(drop_s), 32'd3);
    wr(7'd0, 32'hEE, 1'b0, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0);
    chk("t6_drop4", 32'(drop), 32'd4);
    chk("t6_small_saturated", 32'(drop_s), 32'd3);
    wr(7'd0, 32'hEF, 1'b0, 1'b0, 1'b0);
    strobe(1'b0, 1'b1, 1'b0);
    chk("t6_drop_abort", 32'(drop), 32'd4);
    chk("t6_still_full", 32'(full), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
